// File: rtl/pio_pkg.sv
// Shared register map, bit indices and pulse-engine state type for the output PIO.
package pio_pkg;

  localparam logic [2:0] PIO_ADDR_DATA      = 3'd0;
  localparam logic [2:0] PIO_ADDR_PULSE_LEN = 3'd1;
  localparam logic [2:0] PIO_ADDR_STATUS    = 3'd2;
  localparam logic [2:0] PIO_ADDR_CTRL      = 3'd3;
  localparam logic [2:0] PIO_ADDR_OUTSET    = 3'd4;
  localparam logic [2:0] PIO_ADDR_OUTCLEAR  = 3'd5;
  localparam logic [2:0] PIO_ADDR_PULSE     = 3'd6;

  localparam int PIO_ST_BUSY     = 0;
  localparam int PIO_ST_ERR      = 1;
  localparam int PIO_ST_DONE     = 2;
  localparam int PIO_CTRL_IRQ_EN = 0;

  typedef enum logic {
    PT_IDLE   = 1'b0,
    PT_ACTIVE = 1'b1
  } pt_state_t;

endpackage

// File: rtl/avalon_pio_out_pulse_if.sv
// Avalon-MM s1 slave bundle for the output PIO.
// Handshake: a write is taken on every rising clk edge where chipselect & ~write_n;
// a read is chipselect & write_n and readdata is combinational from address (no wait states).
interface avalon_pio_out_pulse_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/pio_pulse_timer.sv
// Loadable down-counter timing one output pulse; state is exported for observation.
module pio_pulse_timer
  import pio_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] len,
  output logic             busy,
  output logic             done_pulse,
  output pt_state_t        state
);

  pt_state_t        state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= PT_IDLE;
      cnt_q <= '0;
    end else begin
      state <= state_d;
      cnt_q <= cnt_d;
    end
  end

  // The edge on which the count reads 1 is the last cycle of the pulse.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt_q;
    done_pulse = 1'b0;
    case (state)
      PT_IDLE: begin
        if (load) begin
          state_d = PT_ACTIVE;
          cnt_d   = len;
        end
      end
      PT_ACTIVE: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d    = PT_IDLE;
          cnt_d      = '0;
          done_pulse = 1'b1;
        end
      end
      default: state_d = PT_IDLE;
    endcase
  end

  assign busy = (state == PT_ACTIVE);

endmodule

// File: rtl/avalon_pio_out_pulse.sv
// Avalon-MM output PIO with atomic set/clear and, when PIO_OUT_PULSE_EN is defined,
// a hardware-timed pulse engine with STATUS/CTRL registers and a completion irq.
module avalon_pio_out_pulse
  import pio_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 1,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE   = DATA_WIDTH'(1),
  parameter int                    PULSE_CNT_W   = 16,
  parameter int                    PULSE_DEFAULT = 100
) (
  input  logic                   clk,
  input  logic                   reset_n,
  avalon_pio_out_pulse_if.slave  s1,
  output logic [DATA_WIDTH-1:0]  out_port,
  output logic                   irq
);

  logic                  wr;
  logic [DATA_WIDTH-1:0] wd_data;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  unused_wd;

  assign wr        = s1.chipselect & ~s1.write_n;
  assign wd_data   = s1.writedata[DATA_WIDTH-1:0];
  assign unused_wd = ^s1.writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= RESET_VALUE;
    end else if (wr) begin
      case (s1.address)
        PIO_ADDR_DATA:     data_out <= wd_data;
        PIO_ADDR_OUTSET:   data_out <= data_out | wd_data;
        PIO_ADDR_OUTCLEAR: data_out <= data_out & ~wd_data;
        default:           data_out <= data_out;
      endcase
    end
  end

`ifdef PIO_OUT_PULSE_EN
  logic [PULSE_CNT_W-1:0] pulse_len;
  logic [PULSE_CNT_W-1:0] wd_len;
  logic [DATA_WIDTH-1:0]  pulse_mask;
  logic                   err;
  logic                   done;
  logic                   irq_en;
  logic                   busy;
  logic                   done_pulse;
  logic                   pulse_wr;
  logic                   status_wr;
  logic                   pulse_load;
  pt_state_t              pulse_state;

  assign wd_len    = s1.writedata[PULSE_CNT_W-1:0];
  assign pulse_wr  = wr && (s1.address == PIO_ADDR_PULSE);
  assign status_wr = wr && (s1.address == PIO_ADDR_STATUS);
  // Busy includes the completing cycle, so a PULSE on that edge is rejected.
  assign pulse_load = pulse_wr && !busy && (wd_data != '0) && (pulse_len != '0);

  pio_pulse_timer #(
    .CNT_W (PULSE_CNT_W)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (pulse_load),
    .len        (pulse_len),
    .busy       (busy),
    .done_pulse (done_pulse),
    .state      (pulse_state)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pulse_len  <= PULSE_CNT_W'(PULSE_DEFAULT);
      pulse_mask <= '0;
      err        <= 1'b0;
      done       <= 1'b0;
      irq_en     <= 1'b0;
    end else begin
      if (wr && (s1.address == PIO_ADDR_PULSE_LEN)) pulse_len <= wd_len;
      if (wr && (s1.address == PIO_ADDR_CTRL))      irq_en <= s1.writedata[PIO_CTRL_IRQ_EN];

      if (pulse_load)      pulse_mask <= wd_data;
      else if (done_pulse) pulse_mask <= '0;

      if (pulse_wr && busy)                          err <= 1'b1;
      else if (status_wr && s1.writedata[PIO_ST_ERR]) err <= 1'b0;

      // Completion outranks a simultaneous W1C.
      if (done_pulse)                                  done <= 1'b1;
      else if (status_wr && s1.writedata[PIO_ST_DONE]) done <= 1'b0;
    end
  end

  assign out_port = data_out ^ ((pulse_state == PT_ACTIVE) ? pulse_mask : '0);
  assign irq      = done & irq_en;

  always_comb begin
    s1.readdata = '0;
    case (s1.address)
      PIO_ADDR_DATA:      s1.readdata = 32'(data_out);
      PIO_ADDR_PULSE_LEN: s1.readdata = 32'(pulse_len);
      PIO_ADDR_STATUS: begin
        s1.readdata[PIO_ST_BUSY] = busy;
        s1.readdata[PIO_ST_ERR]  = err;
        s1.readdata[PIO_ST_DONE] = done;
      end
      PIO_ADDR_CTRL:      s1.readdata[PIO_CTRL_IRQ_EN] = irq_en;
      default:            s1.readdata = '0;
    endcase
  end
`else
  localparam int unused_pulse_cfg = PULSE_CNT_W + PULSE_DEFAULT;

  assign out_port = data_out;
  assign irq      = 1'b0;

  always_comb begin
    s1.readdata = '0;
    if (s1.address == PIO_ADDR_DATA) s1.readdata = 32'(data_out);
  end
`endif

endmodule
